// File: rtl/touch_adc_pkg.sv
// Shared constants, FSM state type and helpers for the touch-screen ADC controller.
package touch_adc_pkg;

    // 12-bit conversion, differential reference, power-down between conversions
    localparam logic [7:0] CMD_X           = 8'hD0;
    localparam logic [7:0] CMD_Y           = 8'h90;
    localparam int         FRAME_CLKS      = 24;
    localparam int         DATA_FIRST_EDGE = 10;
    localparam int         DATA_BITS       = 12;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        CONV_X,
        CONV_Y,
        PUBLISH,
        GAP
    } touch_state_e;

    // Mean of two samples: summed at 13 bits so the carry survives, then truncated.
    function automatic logic [DATA_BITS-1:0] avg12(input logic [DATA_BITS-1:0] a,
                                                   input logic [DATA_BITS-1:0] b);
        logic [DATA_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_BITS:1];
    endfunction

endpackage

// File: rtl/touch_adc_spi_ctrl_if.sv
// Pins between the controller and the touch-screen ADC (serial bus plus pen interrupt).
interface touch_adc_spi_ctrl_if;
    logic pen_irq_n;
    logic adc_dout;
    logic adc_din;
    logic adc_dclk;
    logic adc_cs_n;

    modport master (
        input  pen_irq_n,
        input  adc_dout,
        output adc_din,
        output adc_dclk,
        output adc_cs_n
    );

    modport slave (
        output pen_irq_n,
        output adc_dout,
        input  adc_din,
        input  adc_dclk,
        input  adc_cs_n
    );
endinterface

// File: rtl/touch_spi_xfer.sv
// One 24-DCLK conversion frame: shifts the command byte out, samples the 12-bit result,
// then holds cs_n high for one DCLK half-period before reporting done.
// Frame time is phases 0..47 (even = DCLK low, odd = DCLK high) plus tail phase 48,
// each CLK_DIV clk long. A new start is accepted on the done cycle so frames chain.
module touch_spi_xfer
    import touch_adc_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           cmd,
    output logic                 done,
    output logic [DATA_BITS-1:0] result,
    input  logic                 adc_dout,
    output logic                 adc_din,
    output logic                 adc_dclk,
    output logic                 adc_cs_n
);

    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int HALVES    = 2 * FRAME_CLKS;
    localparam int PH_W      = $clog2(HALVES + 1);
    // rising edge k is the entry into phase 2k-1
    localparam int SAMPLE_LO = 2 * DATA_FIRST_EDGE - 1;
    localparam int SAMPLE_HI = 2 * (DATA_FIRST_EDGE + DATA_BITS - 1) - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_TAIL  = PH_W'(HALVES);
    localparam logic [PH_W-1:0]  PH_SLO   = PH_W'(SAMPLE_LO);
    localparam logic [PH_W-1:0]  PH_SHI   = PH_W'(SAMPLE_HI);

    logic                 busy_q, busy_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [7:0]           sh_q, sh_d;
    logic [DATA_BITS-1:0] res_q, res_d;
    logic                 dclk_q, dclk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 din_q, din_d;

    logic                 half_end;
    logic [PH_W-1:0]      ph_nxt;

    assign half_end = (div_q == DIV_LAST);
    assign ph_nxt   = ph_q + 1'b1;
    assign done     = busy_q & half_end & (ph_q == PH_TAIL);

    assign result   = res_q;
    assign adc_din  = din_q;
    assign adc_dclk = dclk_q;
    assign adc_cs_n = cs_n_q;

    // Half-period sequencer: DCLK/DIN/CS_N edges land on half-period boundaries.
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        ph_d   = ph_q;
        sh_d   = sh_q;
        res_d  = res_q;
        dclk_d = dclk_q;
        cs_n_d = cs_n_q;
        din_d  = din_q;
        if (start && (!busy_q || done)) begin
            busy_d = 1'b1;
            div_d  = '0;
            ph_d   = '0;
            sh_d   = {cmd[6:0], 1'b0};
            cs_n_d = 1'b0;
            dclk_d = 1'b0;
            din_d  = cmd[7];
        end else if (busy_q) begin
            if (!half_end) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (ph_q == PH_TAIL) begin
                    busy_d = 1'b0;
                end else begin
                    ph_d = ph_nxt;
                    if (ph_nxt == PH_TAIL) begin
                        cs_n_d = 1'b1;
                        dclk_d = 1'b0;
                        din_d  = 1'b0;
                    end else if (ph_nxt[0]) begin
                        dclk_d = 1'b1;
                        if (ph_nxt >= PH_SLO && ph_nxt <= PH_SHI)
                            res_d = {res_q[DATA_BITS-2:0], adc_dout};
                    end else begin
                        // falling edge: next command bit, zeros once the byte is out
                        dclk_d = 1'b0;
                        din_d  = sh_q[7];
                        sh_d   = {sh_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Frame state; reset drops cs_n/dclk at once so a frame in flight is abandoned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            ph_q   <= '0;
            sh_q   <= '0;
            res_q  <= '0;
            dclk_q <= 1'b0;
            cs_n_q <= 1'b1;
            din_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            ph_q   <= ph_d;
            sh_q   <= sh_d;
            res_q  <= res_d;
            dclk_q <= dclk_d;
            cs_n_q <= cs_n_d;
            din_q  <= din_d;
        end
    end

endmodule

// File: rtl/touch_adc_spi_ctrl.sv
// Touch-screen ADC controller: debounces the pen interrupt, runs back-to-back X/Y
// conversions, publishes coordinates, then waits a gap before re-checking the pen.
// Optional build macro TOUCH_AVG_EN: publish the mean of every two conversion pairs.
module touch_adc_spi_ctrl
    import touch_adc_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int DEB_CYCLES = 50000,
    parameter int GAP_CYCLES = 500000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    touch_adc_spi_ctrl_if.master        adc,
    output logic [11:0]                 touch_x,
    output logic [11:0]                 touch_y,
    output logic                        touch_valid,
    output logic                        pen_down
);

    localparam int CNT_MAX = (DEB_CYCLES > GAP_CYCLES) ? DEB_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic               pen_meta_q, pen_sync_q;
    touch_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        x_raw_q, x_raw_d;
    logic [11:0]        tx_q, tx_d;
    logic [11:0]        ty_q, ty_d;
    logic               tv_q, tv_d;
    logic               pd_q, pd_d;

    logic               xfer_start;
    logic [7:0]         xfer_cmd;
    logic               xfer_done;
    logic [11:0]        xfer_result;

`ifdef TOUCH_AVG_EN
    logic               have_q, have_d;
    logic [11:0]        acc_x_q, acc_x_d;
    logic [11:0]        acc_y_q, acc_y_d;
`endif

    // Only a start from CONV_X launches the Y frame.
    assign xfer_cmd    = (state_q == CONV_X) ? CMD_Y : CMD_X;

    assign touch_x     = tx_q;
    assign touch_y     = ty_q;
    assign touch_valid = tv_q;
    assign pen_down    = pd_q;

    touch_spi_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (xfer_start),
        .cmd      (xfer_cmd),
        .done     (xfer_done),
        .result   (xfer_result),
        .adc_dout (adc.adc_dout),
        .adc_din  (adc.adc_din),
        .adc_dclk (adc.adc_dclk),
        .adc_cs_n (adc.adc_cs_n)
    );

    // Two-flop synchronizer for the asynchronous pen interrupt (idles high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pen_meta_q <= 1'b1;
            pen_sync_q <= 1'b1;
        end else begin
            pen_meta_q <= adc.pen_irq_n;
            pen_sync_q <= pen_meta_q;
        end
    end

    // Next-state and output logic; starts are issued combinationally so frames chain
    // without dead cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_raw_d    = x_raw_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        tv_d       = 1'b0;
        pd_d       = pd_q;
        xfer_start = 1'b0;
`ifdef TOUCH_AVG_EN
        have_d     = have_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef TOUCH_AVG_EN
                have_d = 1'b0;
`endif
                cnt_d = '0;
                if (!pen_sync_q) begin
                    // this cycle already counts as the first low one
                    state_d = DEBOUNCE;
                    cnt_d   = CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (pen_sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d    = CONV_X;
                    cnt_d      = '0;
                    xfer_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONV_X: begin
                // pen interrupt is meaningless while cs_n is low, so no pen check here
                if (xfer_done) begin
                    x_raw_d    = xfer_result;
                    state_d    = CONV_Y;
                    xfer_start = 1'b1;
                end
            end
            CONV_Y: begin
                if (xfer_done) begin
`ifdef TOUCH_AVG_EN
                    if (have_q) begin
                        state_d = PUBLISH;
                    end else begin
                        // hold the first pair and go fetch its partner
                        acc_x_d = x_raw_q;
                        acc_y_d = xfer_result;
                        have_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = GAP;
                    end
`else
                    state_d = PUBLISH;
`endif
                end
            end
            PUBLISH: begin
`ifdef TOUCH_AVG_EN
                tx_d   = avg12(acc_x_q, x_raw_q);
                ty_d   = avg12(acc_y_q, xfer_result);
                have_d = 1'b0;
`else
                tx_d   = x_raw_q;
                ty_d   = xfer_result;
`endif
                tv_d    = 1'b1;
                pd_d    = 1'b1;
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d = '0;
                    if (!pen_sync_q) begin
                        state_d    = CONV_X;
                        xfer_start = 1'b1;
                    end else begin
                        // release: keep the last coordinates, drop any pending pair
                        state_d = IDLE;
                        pd_d    = 1'b0;
`ifdef TOUCH_AVG_EN
                        have_d  = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state and published outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_raw_q <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            tv_q    <= 1'b0;
            pd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_raw_q <= x_raw_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tv_q    <= tv_d;
            pd_q    <= pd_d;
        end
    end

`ifdef TOUCH_AVG_EN
    // First-of-two pair held for averaging.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            have_q  <= 1'b0;
            acc_x_q <= '0;
            acc_y_q <= '0;
        end else begin
            have_q  <= have_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
        end
    end
`endif

endmodule

// File: tb/tb_touch_adc_spi_ctrl.sv
// Directed bench for touch_adc_spi_ctrl with a behavioural ADC model.
// With TOUCH_AVG_EN defined the publish step checks the averaged result instead.
module tb_touch_adc_spi_ctrl;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 20;
    localparam int GAP     = 200;
    localparam int TCLK    = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] touch_x, touch_y;
    logic        touch_valid, pen_down;

    touch_adc_spi_ctrl_if adc ();

    touch_adc_spi_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .DEB_CYCLES (DEB),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .adc         (adc),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .touch_valid (touch_valid),
        .pen_down    (pen_down)
    );

    always #(TCLK/2) clk = ~clk;

    int          ncmp = 0, nerr = 0;
    int          nvalid = 0, nfr_start = 0, nfr_end = 0, redge = 0;
    logic [7:0]  cmd_rx = 8'h00;
    logic [7:0]  cmd_log [0:15];
    longint      cs_hi_log [0:15];
    time         t_e1 = 0, t_e2 = 0, t_fall1 = 0, t_rise = 0, t_valid1 = 0;
    logic [11:0] x_val = 12'hABC, y_val = 12'h123;
    logic [11:0] word;

    // ADC model: frame bookkeeping on chip-select edges
    always @(negedge adc.adc_cs_n) begin
        nfr_start = nfr_start + 1;
        redge  = 0;
        cmd_rx = 8'h00;
        if (nfr_start == 1) t_fall1 = $time;
        if (nfr_start >= 1 && nfr_start <= 16) cs_hi_log[nfr_start-1] = longint'($time - t_rise);
    end

    always @(posedge adc.adc_cs_n) begin
        nfr_end = nfr_end + 1;
        t_rise  = $time;
    end

    // ADC model: latch command bits on rising edges 1..8
    always @(posedge adc.adc_dclk) begin
        redge = redge + 1;
        if (redge <= 8) cmd_rx = {cmd_rx[6:0], adc.adc_din};
        if (redge == 8 && nfr_start >= 1 && nfr_start <= 16) cmd_log[nfr_start-1] = cmd_rx;
        if (nfr_start == 1 && redge == 1) t_e1 = $time;
        if (nfr_start == 1 && redge == 2) t_e2 = $time;
    end

    // ADC model: D11 after the falling edge following rising edge 9, one bit per falling edge
    always @(negedge adc.adc_dclk) begin
        word = (cmd_rx == 8'hD0) ? x_val : y_val;
        if (redge >= 9 && redge <= 20) adc.adc_dout = word[20-redge];
        else                           adc.adc_dout = 1'b0;
    end

    always @(negedge clk) begin
        if (touch_valid === 1'b1) begin
            nvalid = nvalid + 1;
            if (nvalid == 1) t_valid1 = $time;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (nvalid >= n) ok = 1'b1;
        end
    endtask

    initial begin
        bit  ok;
        int  lat;
        int  nv0;

        adc.pen_irq_n = 1'b1;
        adc.adc_dout  = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_cs_n",  32'(adc.adc_cs_n), 32'd1);
        chk("rst_dclk",  32'(adc.adc_dclk), 32'd0);
        chk("rst_din",   32'(adc.adc_din),  32'd0);
        chk("rst_x",     32'(touch_x),      32'd0);
        chk("rst_y",     32'(touch_y),      32'd0);
        chk("rst_valid", 32'(touch_valid),  32'd0);
        chk("rst_pen",   32'(pen_down),     32'd0);
        nvalid = 0; nfr_start = 0; nfr_end = 0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // pen low one cycle short of the debounce time: nothing may start
        adc.pen_irq_n = 1'b0;
        repeat (DEB - 1) @(negedge clk);
        adc.pen_irq_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("short_frames", 32'(nfr_start),    32'd0);
        chk("short_cs_n",   32'(adc.adc_cs_n), 32'd1);
        chk("short_pen",    32'(pen_down),     32'd0);

`ifdef TOUCH_AVG_EN
        // two pairs averaged: X 0x100 then 0x203 -> 0x181
        x_val = 12'h100;
        adc.pen_irq_n = 1'b0;
        for (int i = 0; i < 3000 && nfr_end < 2; i++) @(negedge clk);
        x_val = 12'h203;
        wait_valid(1, 4000, ok);
        chk("avg_valid_seen", 32'(ok),      32'd1);
        chk("avg_x",          32'(touch_x), 32'h181);
        chk("avg_y",          32'(touch_y), 32'h123);
        chk("avg_pen",        32'(pen_down), 32'd1);
        chk("avg_frames",     32'(nfr_start), 32'd4);
        adc.pen_irq_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("avg_one_valid",  32'(nvalid),   32'd1);
        chk("avg_pen_rel",    32'(pen_down), 32'd0);
`else
        // held pen: one X/Y pair published
        adc.pen_irq_n = 1'b0;
        wait_valid(1, 3000, ok);
        chk("valid1_seen", 32'(ok),          32'd1);
        chk("x1",          32'(touch_x),     32'hABC);
        chk("y1",          32'(touch_y),     32'h123);
        chk("pen1",        32'(pen_down),    32'd1);
        chk("cmd_x",       32'(cmd_log[0]),  32'hD0);
        chk("cmd_y",       32'(cmd_log[1]),  32'h90);
        chk("dclk_period", 32'(t_e2 - t_e1), 32'(2 * CLK_DIV * TCLK));
        lat = int'((t_valid1 - t_fall1) / TCLK);
        chk("latency_in_range",
            32'((lat >= 98 * CLK_DIV) && (lat <= 98 * CLK_DIV + 4)), 32'd1);

        // release during the gap: outputs hold, no new frame, pen_down drops
        adc.pen_irq_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("rel_pen",    32'(pen_down),  32'd0);
        chk("rel_x",      32'(touch_x),   32'hABC);
        chk("rel_y",      32'(touch_y),   32'h123);
        chk("rel_valids", 32'(nvalid),    32'd1);
        chk("rel_frames", 32'(nfr_start), 32'd2);

        // new touch, then a second pair through the gap loop with extreme codes
        x_val = 12'h5A5; y_val = 12'h0F0;
        adc.pen_irq_n = 1'b0;
        wait_valid(2, 3000, ok);
        chk("valid2_seen", 32'(ok),      32'd1);
        chk("x2",          32'(touch_x), 32'h5A5);
        chk("y2",          32'(touch_y), 32'h0F0);
        x_val = 12'hFFF; y_val = 12'h000;
        wait_valid(3, 3000, ok);
        chk("valid3_seen", 32'(ok),       32'd1);
        chk("x3",          32'(touch_x),  32'hFFF);
        chk("y3",          32'(touch_y),  32'h000);
        chk("pen3",        32'(pen_down), 32'd1);
        chk("gap_cs_high", 32'(cs_hi_log[4] >= longint'(GAP * TCLK)), 32'd1);
`endif

        // reset at rising edge 15 of a Y frame: frame aborted, nothing published
        adc.pen_irq_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (cmd_rx == 8'h90 && redge == 15 && adc.adc_dclk === 1'b1) ok = 1'b1;
        end
        chk("yedge15_seen", 32'(ok), 32'd1);
        nv0 = nvalid;
        reset_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(adc.adc_cs_n), 32'd1);
        chk("abort_dclk", 32'(adc.adc_dclk), 32'd0);
        chk("abort_x",    32'(touch_x),      32'd0);
        chk("abort_y",    32'(touch_y),      32'd0);
        chk("abort_pen",  32'(pen_down),     32'd0);
        adc.pen_irq_n = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (600) @(negedge clk);
        chk("abort_no_valid", 32'(nvalid),       32'(nv0));
        chk("abort_x_hold",   32'(touch_x),      32'd0);
        chk("abort_idle_cs",  32'(adc.adc_cs_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/touch_adc_spi_ctrl.md
TOUCH_ADC_SPI_CTRL -- requirements
Module: touch_adc_spi_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25, clk cycles per DCLK half-period (50 MHz clk gives 1 MHz DCLK); legal range 2..255.
REQ-002 SHALL have parameter DEB_CYCLES, default 50000, clk cycles pen_irq_n must stay low before the first conversion.
REQ-003 SHALL have parameter GAP_CYCLES, default 500000, clk cycles with adc_cs_n high between sample pairs.
REQ-004 Reset reset_n, asynchronous, active-low; clock clk.
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 pen_irq_n  in  1  ADC pen interrupt, asynchronous, low = touched.
REQ-008 adc_dout  in  1  ADC serial data out.
REQ-009 adc_din  out  1  ADC serial data in (command bits).
REQ-010 adc_dclk  out  1  ADC serial clock, idle low.
REQ-011 adc_cs_n  out  1  ADC chip select, active low.
REQ-012 touch_x  out  12  latest published X coordinate; feeds the touch-X PIO input port.
REQ-013 touch_y  out  12  latest published Y coordinate.
REQ-014 touch_valid  out  1  one-clk pulse when touch_x/touch_y update.
REQ-015 pen_down  out  1  level, high while a debounced touch is active.

Function
REQ-016 pen_irq_n SHALL pass through a 2-FF synchronizer before any use.
REQ-017 The FSM SHALL have states IDLE, DEBOUNCE, CONV_X, CONV_Y, PUBLISH, GAP.
REQ-018 IDLE -> DEBOUNCE on synchronized pen low; DEBOUNCE -> IDLE if pen goes high before DEB_CYCLES; DEBOUNCE -> CONV_X after DEB_CYCLES consecutive low cycles.
REQ-019 Each conversion SHALL be one frame: adc_cs_n low, then 24 DCLK periods, then adc_cs_n high for at least one DCLK half-period.
REQ-020 Command byte SHALL be 0xD0 for X and 0x90 for Y: 12-bit, differential, PD=00.
REQ-021 adc_din SHALL change only while adc_dclk is low, MSB first, valid before rising edges 1..8; adc_din SHALL be 0 otherwise.
REQ-022 adc_dout SHALL be sampled on rising edges 10..21, D11 first, into a 12-bit result.
REQ-023 CONV_X -> CONV_Y -> PUBLISH SHALL be back-to-back, with no pen check in between; PENIRQ is invalid while cs_n is low.
REQ-024 PUBLISH SHALL update touch_x and touch_y in the same clk, pulse touch_valid for exactly one clk, and set pen_down=1, then go to GAP.
REQ-025 GAP SHALL hold cs_n high for GAP_CYCLES, then sample the synchronized pen.
REQ-026 At the end of GAP: pen low -> CONV_X; pen high -> IDLE with pen_down=0.
REQ-027 On pen release, touch_x and touch_y SHALL hold their last values; touch_valid SHALL NOT pulse.
REQ-028 Latency from DEBOUNCE exit to the touch_valid pulse SHALL be 2*(24*2*CLK_DIV + CLK_DIV) + 1 clk +/-2.

Reset
REQ-029 On reset: adc_cs_n=1, adc_dclk=0, adc_din=0, touch_x=0, touch_y=0, touch_valid=0, pen_down=0, FSM=IDLE, all counters 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; no partial result SHALL be published.

Configuration
REQ-031 Macro TOUCH_AVG_EN: when defined, PUBLISH SHALL occur only after every second conversion pair. Output is (a+b)>>1 per axis, summed at 13 bits and truncated. The first pair after DEBOUNCE is never published alone.
REQ-032 When TOUCH_AVG_EN is undefined, every pair SHALL be published raw; no accumulator logic SHALL exist.
REQ-033 With TOUCH_AVG_EN, pen release between the two pairs SHALL discard the pending pair.

Structure
REQ-034 Package touch_adc_pkg SHALL hold CMD_X, CMD_Y, FRAME_CLKS=24, DATA_FIRST_EDGE=10, DATA_BITS=12, and the FSM state enum.
REQ-035 The 24-clock frame engine SHALL be sub-module touch_spi_xfer, with ports start, cmd[7:0], done, result[11:0] and the ADC pins.

Verification
REQ-036 ADC model returns X=0xABC, Y=0x123; pen held low -> one touch_valid with touch_x=0xABC, touch_y=0x123, pen_down=1.
REQ-037 Pen low for DEB_CYCLES-1 then high -> no frame (cs_n stays 1), pen_down=0.
REQ-038 Check DIN bits on rising edges 1..8 -> 1101_0000 in the X frame, 1001_0000 in the Y frame; DCLK period = 2*CLK_DIV clk.
REQ-039 Pen released during GAP after a sample -> pen_down=0, outputs hold 0xABC/0x123, no further frames.
REQ-040 reset_n asserted at rising edge 15 of the Y frame -> cs_n=1 and dclk=0 asynchronously; touch_x/touch_y=0; no touch_valid.
REQ-041 TOUCH_AVG_EN, X samples 0x100 then 0x203 -> single touch_valid with touch_x=0x181.
